// File: rtl/cpu7_muldiv_arbiter.sv
// Round-robin arbiter sharing one multiply/divide unit among CORES cpu7 cores.
// Defining CPU7_MULDIV_ARB_TIMEOUT_EN adds a WAIT-state watchdog with MDU abort.
module cpu7_muldiv_arbiter #(
   parameter  int CORES      = 2,
   parameter  int DATA_WIDTH = 28,
   parameter  int OP_WIDTH   = 2,
   parameter  int TIMEOUT    = 64,
   localparam int IW         = $clog2(CORES > 1 ? CORES : 2)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CORES-1:0]               req_valid,
   output logic [CORES-1:0]               req_ready,
   input  logic [CORES*OP_WIDTH-1:0]      req_op,
   input  logic [CORES*DATA_WIDTH-1:0]    req_a,
   input  logic [CORES*DATA_WIDTH-1:0]    req_b,
   output logic [CORES-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_result,
   output logic                           rsp_err,
   output logic                           mdu_start,
   output logic [OP_WIDTH-1:0]            mdu_op,
   output logic [DATA_WIDTH-1:0]          mdu_a,
   output logic [DATA_WIDTH-1:0]          mdu_b,
   input  logic                           mdu_done,
   input  logic [DATA_WIDTH-1:0]          mdu_result,
   output logic                           mdu_abort,
   output logic                           busy,
   output logic [IW-1:0]                  grant_id
);

   // Handshake: a request transfers on a rising edge where req_valid[i] and
   // req_ready[i] are both high; ready is only ever offered in IDLE.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   if (CORES < 1 || TIMEOUT < 2) begin : g_param_check
      $error("cpu7_muldiv_arbiter: CORES must be >= 1 and TIMEOUT >= 2");
   end

   state_t                  r_state;
   state_t                  w_next_state;
   logic [IW-1:0]           r_last_grant;
   logic [IW-1:0]           r_grant_id;
   logic [OP_WIDTH-1:0]     r_mdu_op;
   logic [DATA_WIDTH-1:0]   r_mdu_a;
   logic [DATA_WIDTH-1:0]   r_mdu_b;
   logic [CORES-1:0]        r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_result;
   logic                    r_rsp_err;
   logic                    r_mdu_abort;

   logic [IW-1:0]           w_winner;
   logic [IW-1:0]           w_idx;
   logic                    w_accept;
   logic                    w_done_take;
   logic                    w_timeout;
   logic [CORES-1:0]        w_ready;
   logic [CORES-1:0]        w_grant_oh;
   logic [OP_WIDTH-1:0]     w_sel_op;
   logic [DATA_WIDTH-1:0]   w_sel_a;
   logic [DATA_WIDTH-1:0]   w_sel_b;

   // Scan from last_grant+CORES down to last_grant+1 so the nearest requester wins.
   always_comb begin
      w_winner = '0;
      w_idx    = '0;
      for (int k = CORES; k >= 1; k--) begin
         w_idx = IW'((int'(r_last_grant) + k) % CORES);
         if (req_valid[w_idx]) w_winner = w_idx;
      end
   end

   assign w_accept    = (r_state == S_IDLE) && (|req_valid);
   assign w_done_take = (r_state == S_WAIT) && mdu_done;

   always_comb begin
      w_ready    = '0;
      w_grant_oh = '0;
      w_sel_op   = '0;
      w_sel_a    = '0;
      w_sel_b    = '0;
      for (int i = 0; i < CORES; i++) begin
         w_grant_oh[i] = (r_grant_id == IW'(i));
         if (w_winner == IW'(i)) begin
            w_ready[i] = w_accept;
            w_sel_op   = req_op[i*OP_WIDTH +: OP_WIDTH];
            w_sel_a    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_b    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef CPU7_MULDIV_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] r_wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_wait_cnt <= '0;
      else if (r_state != S_WAIT) r_wait_cnt <= '0;
      else                        r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   // A done arriving in the expiry cycle takes precedence over the abort.
   assign w_timeout = (r_state == S_WAIT) && !mdu_done && (r_wait_cnt == CW'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
         S_ISSUE: w_next_state = S_WAIT;
         S_WAIT:  if (w_done_take || w_timeout) w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= IW'(CORES - 1);
         r_grant_id   <= '0;
         r_mdu_op     <= '0;
         r_mdu_a      <= '0;
         r_mdu_b      <= '0;
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_rsp_err    <= 1'b0;
         r_mdu_abort  <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_rsp_valid <= '0;
         r_mdu_abort <= 1'b0;
         if (w_accept) begin
            r_grant_id <= w_winner;
            r_mdu_op   <= w_sel_op;
            r_mdu_a    <= w_sel_a;
            r_mdu_b    <= w_sel_b;
         end
         if (w_done_take) begin
            r_rsp_valid  <= w_grant_oh;
            r_rsp_result <= mdu_result;
            r_rsp_err    <= 1'b0;
         end else if (w_timeout) begin
            r_rsp_valid  <= w_grant_oh;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
            r_mdu_abort  <= 1'b1;
         end
         if (r_state == S_RESP) r_last_grant <= r_grant_id;
      end
   end

   assign req_ready  = w_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_err    = r_rsp_err;
   assign mdu_start  = (r_state == S_ISSUE);
   assign mdu_op     = r_mdu_op;
   assign mdu_a      = r_mdu_a;
   assign mdu_b      = r_mdu_b;
   assign mdu_abort  = r_mdu_abort;
   assign busy       = (r_state != S_IDLE);
   assign grant_id   = r_grant_id;

endmodule

// File: doc/cpu7_muldiv_arbiter.md
# cpu7_muldiv_arbiter

Round-robin arbiter that shares one multiply/divide unit (MDU) among the `CORES` cpu7 cores of `cpu7_soc`. It accepts one operation at a time from any core over a valid/ready handshake, issues it to the MDU, waits for completion, and returns the result to the requesting core as a one-cycle response pulse. It sits between the per-core execute stages and the single shared MDU instance.

## Interface
Parameters:
- `CORES`, 2, number of requesting cores (≥1)
- `DATA_WIDTH`, 28, operand/result width; matches `MUL_DIV_DATA_WIDTH`
- `OP_WIDTH`, 2, MDU opcode width (passed through, not decoded)
- `TIMEOUT`, 64, watchdog limit in cycles while waiting on the MDU (≥2; used only with the macro)

Ports (`IW` = `$clog2(CORES>1 ? CORES : 2)`):
- `clk`  in  1  sole clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  CORES  per-core request
- `req_ready`  out  CORES  per-core accept; one-hot or zero
- `req_op`  in  CORES*OP_WIDTH  packed opcodes, core i at [i*OP_WIDTH +: OP_WIDTH]
- `req_a`, `req_b`  in  CORES*DATA_WIDTH  packed operands, same packing
- `rsp_valid`  out  CORES  one-cycle, one-hot response pulse
- `rsp_result`  out  DATA_WIDTH  result, valid while any `rsp_valid` bit is high
- `rsp_err`  out  1  high with `rsp_valid` on watchdog abort
- `mdu_start`  out  1  one-cycle issue pulse
- `mdu_op`  out  OP_WIDTH; `mdu_a`, `mdu_b`  out  DATA_WIDTH  latched operands, stable from `mdu_start` until response
- `mdu_done`  in  1  MDU completion strobe
- `mdu_result`  in  DATA_WIDTH  sampled when `mdu_done`=1
- `mdu_abort`  out  1  one-cycle abort pulse to the MDU
- `busy`  out  1  high in any state other than IDLE
- `grant_id`  out  IW  index of the current/last granted core

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if any `req_valid`, select the winner by round-robin, searching from `last_grant+1` upward with wrap-around. `req_ready[winner]`=1 combinationally in the same cycle. On that edge: latch op/a/b into `mdu_*`, set `grant_id`, go to ISSUE. `req_ready` is 0 in every other state.
- ISSUE: `mdu_start`=1 for exactly one cycle; go to WAIT.
- WAIT: on `mdu_done`=1, capture `mdu_result` and go to RESP. `mdu_done` is ignored in IDLE, ISSUE and RESP.
- RESP: `rsp_valid[grant_id]`=1 for one cycle with `rsp_result`; set `last_grant`=`grant_id`; go to IDLE.
- Requesters hold `req_valid` and operands stable until `req_ready`. Requests that lose arbitration wait without penalty.
- Fairness: each requester is served within `CORES` transactions.
- CORES=1: arbitration degenerates to a fixed grant to core 0; `grant_id` stays 0.

## Timing
- Reset (async assert, sync release): state=IDLE, `last_grant`=CORES-1 (core 0 has priority first), `grant_id`=0. All registered outputs are 0: `mdu_*`, `rsp_*`, `mdu_start`, `mdu_abort`, `busy`.
- Accept at cycle T → `mdu_start` at T+1 → earliest `mdu_done` at T+2 → `rsp_valid` at T+3. Minimum 4 cycles per transaction, including the IDLE cycle.
- The next accept is possible in the cycle after RESP. There are no back-to-back accepts.
- `rsp_result`/`rsp_err` are registered and hold their value until the next response. `rsp_valid` is registered.
- Reset asserted mid-transaction drops the transaction silently: no response, no `mdu_abort`.

## Configuration
- Macro `CPU7_MULDIV_ARB_TIMEOUT_EN`.
- Defined:
  - WAIT runs a cycle counter, cleared on entry.
  - If `mdu_done` has not arrived when the counter reaches TIMEOUT-1, pulse `mdu_abort` for 1 cycle and go to RESP with `rsp_err`=1 and `rsp_result`=0.
  - If `mdu_done` and the timeout occur in the same cycle, `mdu_done` wins: normal result, no abort.
- Undefined: no counter; WAIT persists until `mdu_done`; `mdu_abort` and `rsp_err` are tied to 0.

## Test plan
- Single request, CORES=2: core 0 requests op=1, a=6, b=7; MDU returns 42 two cycles after start → `req_ready[0]` at T, `mdu_start` at T+1, `rsp_valid`=2'b01 with `rsp_result`=42 one cycle after `mdu_done`.
- Contention, CORES=4: all four cores request continuously → grants in order 0,1,2,3,0; each `rsp_valid` is one-hot and matches `grant_id`.
- Fairness after grant: cores 1 and 2 request, last_grant=1 → core 2 is served before core 1.
- Spurious `mdu_done` pulses in IDLE and ISSUE → no response generated; a later real done completes the transaction normally.
- Reset during WAIT → all outputs return to 0 immediately; after release, core 0 is served first; no stale `rsp_valid`.
- With `CPU7_MULDIV_ARB_TIMEOUT_EN`, TIMEOUT=8, MDU never completes → `mdu_abort` pulse 8 cycles after entering WAIT, then `rsp_valid` with `rsp_err`=1, `rsp_result`=0. If done arrives in the timeout cycle → normal result, no abort.
